// File: rtl/ex_operand_sel_pipe.sv
// EX-stage operand selector: picks one of NUM_IN packed candidates, registers it behind
// a valid/ready handshake with a one-entry skid register, and counts bad selects.
module ex_operand_sel_pipe #(
  parameter int                 DATA_W      = 32,
  parameter int                 NUM_IN      = 6,
  parameter int                 SEL_W       = $clog2(NUM_IN),
  parameter logic [DATA_W-1:0]  DEFAULT_VAL = '0,
  parameter int                 CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_sel_err,
  output logic [CNT_W-1:0]         sel_err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Out-of-range selects fall through to DEFAULT_VAL.
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic [NUM_IN*DATA_W-1:0] cands,
    input logic [SEL_W-1:0]         sel
  );
    logic [DATA_W-1:0] res;
    res = DEFAULT_VAL;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        res = cands[k*DATA_W +: DATA_W];
      end
    end
    return res;
  endfunction

  logic              m_v_r, s_v_r;
  logic [DATA_W-1:0] m_data_r, s_data_r;
  logic              m_err_r, s_err_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] sel_data_s;
  logic              sel_err_s;
  logic              acc_s, pop_s;

  // With a power-of-two candidate count every select encoding is legal.
  generate
    if ((1 << SEL_W) == NUM_IN) begin : g_no_err
      assign sel_err_s = 1'b0;
    end else begin : g_err
      assign sel_err_s = ({1'b0, in_sel} >= (SEL_W+1)'(NUM_IN));
    end
  endgenerate

  assign sel_data_s = pick_operand(in_data, in_sel);
  assign in_ready   = ~s_v_r & ~rst;
  assign acc_s      = in_valid & in_ready;
  assign pop_s      = m_v_r & out_ready;

  assign out_valid   = m_v_r;
  assign out_data    = m_data_r;
  assign out_sel_err = m_err_r;
  assign sel_err_cnt = cnt_r;

  // Main/skid storage: M feeds the outputs, S absorbs the entry accepted while M stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_v_r    <= 1'b0;
      s_v_r    <= 1'b0;
      m_data_r <= {DATA_W{1'b0}};
      s_data_r <= {DATA_W{1'b0}};
      m_err_r  <= 1'b0;
      s_err_r  <= 1'b0;
    end else if (flush) begin
      m_v_r <= 1'b0;
      s_v_r <= 1'b0;
    end else if (!m_v_r || pop_s) begin
      if (s_v_r) begin
        m_data_r <= s_data_r;
        m_err_r  <= s_err_r;
        m_v_r    <= 1'b1;
        s_v_r    <= 1'b0;
      end else if (acc_s) begin
        m_data_r <= sel_data_s;
        m_err_r  <= sel_err_s;
        m_v_r    <= 1'b1;
      end else begin
        m_v_r <= 1'b0;
      end
    end else if (acc_s) begin
      s_data_r <= sel_data_s;
      s_err_r  <= sel_err_s;
      s_v_r    <= 1'b1;
    end else begin
      m_v_r <= m_v_r;
    end
  end

  // Saturating bad-select counter; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (acc_s && sel_err_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_ex_operand_sel_pipe.sv
// Directed and randomised checks of ex_operand_sel_pipe against hand-computed values
// and a queue-based reference model.
module tb_ex_operand_sel_pipe;

  localparam int          DW   = 32;
  localparam int          NIN  = 6;
  localparam int          SW   = 3;
  localparam logic [31:0] DEFV = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready, out_sel_err;
  logic [NIN*DW-1:0] in_data;
  logic [SW-1:0]     in_sel;
  logic [DW-1:0]     out_data;
  logic [7:0]        sel_err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  ex_operand_sel_pipe #(
    .DATA_W(DW), .NUM_IN(NIN), .DEFAULT_VAL(DEFV), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel_err(out_sel_err), .sel_err_cnt(sel_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_fixed_cands();
    for (int k = 0; k < NIN; k++) in_data[k*DW +: DW] = 32'(k * 17);
  endtask

  ent_t        q[$];
  logic [7:0]  cnt_exp;
  logic        acc, pop;
  ent_t        e;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sel = '0;
    load_fixed_cands();

    // Reset state
    cyc();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_cnt", sel_err_cnt, 0);
    rst = 1'b0;
    cyc();
    check_eq("post_rst_in_ready", in_ready, 1);

    // 1: back-to-back selects 0..5, one-cycle latency, no bubbles
    out_ready = 1'b1; in_valid = 1'b1;
    for (int s = 0; s < NIN; s++) begin
      in_sel = SW'(s);
      #1 check_eq("t1_in_ready", in_ready, 1);
      cyc();
      check_eq("t1_out_valid", out_valid, 1);
      check_eq("t1_out_data", out_data, 32'(s * 17));
      check_eq("t1_err", out_sel_err, 0);
    end
    in_valid = 1'b0;
    cyc();
    check_eq("t1_drain", out_valid, 0);

    // 2: back-pressure fills M then S, then drains in order
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd1;
    cyc();
    in_sel = 3'd2;
    cyc();
    check_eq("t2_hold_a", out_data, 32'h11);
    check_eq("t2_in_ready_low", in_ready, 0);
    in_valid = 1'b0;
    cyc();
    check_eq("t2_still_a", out_data, 32'h11);
    out_ready = 1'b1;
    cyc();
    check_eq("t2_b_valid", out_valid, 1);
    check_eq("t2_b_data", out_data, 32'h22);
    check_eq("t2_in_ready_back", in_ready, 1);
    cyc();
    check_eq("t2_empty", out_valid, 0);

    // 3: bad selects, flush during a bad accept, counter saturation
    in_valid = 1'b1; in_sel = 3'd6;
    cyc();
    check_eq("t3_def6", out_data, DEFV);
    check_eq("t3_err6", out_sel_err, 1);
    check_eq("t3_cnt1", sel_err_cnt, 1);
    in_sel = 3'd7;
    cyc();
    check_eq("t3_def7", out_data, DEFV);
    check_eq("t3_cnt2", sel_err_cnt, 2);
    in_valid = 1'b0;
    cyc();
    flush = 1'b1; in_valid = 1'b1; in_sel = 3'd6;
    cyc();
    flush = 1'b0;
    check_eq("t3_flush_drop", out_valid, 0);
    check_eq("t3_flush_cnt", sel_err_cnt, 3);
    in_sel = 3'd7;
    for (int i = 0; i < 260; i++) cyc();
    check_eq("t3_sat", sel_err_cnt, 8'hFF);
    in_sel = 3'd3;
    cyc();
    check_eq("t3_good_data", out_data, 32'h33);
    check_eq("t3_good_err", out_sel_err, 0);
    check_eq("t3_sat_hold", sel_err_cnt, 8'hFF);
    in_valid = 1'b0;
    cyc();

    // 4: flush with M and S full
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd1;
    cyc();
    in_sel = 3'd2;
    cyc();
    check_eq("t4_full", in_ready, 0);
    flush = 1'b1; in_sel = 3'd5;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("t4_out_valid", out_valid, 0);
    check_eq("t4_in_ready", in_ready, 1);
    out_ready = 1'b1;
    cyc();
    check_eq("t4_no_ghost", out_valid, 0);

    // 5: reset mid-stream with S full
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd1;
    cyc();
    in_sel = 3'd2;
    cyc();
    rst = 1'b1; in_valid = 1'b0;
    cyc();
    check_eq("t5_valid", out_valid, 0);
    check_eq("t5_data", out_data, 0);
    check_eq("t5_err", out_sel_err, 0);
    check_eq("t5_cnt", sel_err_cnt, 0);
    check_eq("t5_in_ready_rst", in_ready, 0);
    rst = 1'b0; in_valid = 1'b1; in_sel = 3'd4; out_ready = 1'b1;
    #1 check_eq("t5_in_ready_after", in_ready, 1);
    cyc();
    check_eq("t5_first_valid", out_valid, 1);
    check_eq("t5_first_data", out_data, 32'h44);
    in_valid = 1'b0;
    cyc();
    check_eq("t5_drained", out_valid, 0);

    // 6: random traffic against a queue model
    cnt_exp = 8'd0;
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_sel    = SW'($urandom_range(0, 7));
      for (int k = 0; k < NIN; k++) in_data[k*DW +: DW] = $urandom;
      acc = in_valid && (q.size() < 2);
      pop = out_ready && (q.size() > 0);
      e.err  = (in_sel >= 3'd6);
      e.data = e.err ? DEFV : in_data[in_sel*DW +: DW];
      cyc();
      if (acc && e.err && cnt_exp != 8'hFF) cnt_exp = cnt_exp + 8'd1;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (flush) q.delete();
      check_eq("r_valid", out_valid, (q.size() > 0));
      check_eq("r_in_ready", in_ready, (q.size() < 2));
      check_eq("r_cnt", sel_err_cnt, cnt_exp);
      if (q.size() > 0) begin
        check_eq("r_data", out_data, q[0].data);
        check_eq("r_err", out_sel_err, q[0].err);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
